ram_burst_master: RTL and testbench
===================================

Name: ram_burst_master

Overview:
- Initiator for the single-port RAM port (ena/we/addr/din/dout, combinational read, write on rising clk).
- Accepts burst read/write commands over a valid/ready command channel.
- Streams write data in and read data out over valid/ready channels, driving the RAM port one beat per cycle.
- Sits between processing units and any rams instance.

Parameters:
DATA_, 8, data width; must match the attached RAM.
ADDR_, 8, address width; must match the attached RAM.
LEN_, 8, burst-length field width; beats per burst = cmd_len + 1 (1 .. 2**LEN_).

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_  start address
cmd_len  in  LEN_  beats minus one
wr_valid  in  1  write beat offered
wr_ready  out  1  write beat accepted
wr_data  in  DATA_  write beat data
rd_valid  out  1  read beat valid (registered)
rd_ready  in  1  consumer accepts read beat
rd_data  out  DATA_  read beat data (registered)
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse after the last beat of a burst completes
ram_ena  out  1  RAM enable
ram_we  out  1  RAM write enable
ram_addr  out  ADDR_  RAM address
ram_din  out  DATA_  RAM write data
ram_dout  in  DATA_  RAM read data; valid only while ram_ena = 1 (high-Z otherwise)

Behaviour:
- States: IDLE, WR, RD, FIN.
- Async reset (rst_n low):
  - State returns to IDLE; any in-flight burst is abandoned.
  - rd_valid, rd_data, done, busy, ram_ena, ram_we, ram_addr, ram_din all read 0.
  - cmd_ready and wr_ready are 0 while rst_n is low.
- IDLE:
  - cmd_ready = 1; ram_ena = ram_we = 0.
  - On cmd_valid & cmd_ready: latch cur_addr = cmd_addr, wr_cnt = rd_iss = cmd_len. Next state is WR if cmd_write, else RD.
  - The command channel is ignored in all other states.
- WR:
  - wr_ready = 1; ram_ena = ram_we = wr_valid.
  - ram_addr = cur_addr; ram_din = wr_data (combinational, zero added latency).
  - Write lands on the edge where wr_valid = 1.
  - Per accepted beat: cur_addr += 1; if wr_cnt == 0, go to FIN, else wr_cnt -= 1.
  - wr_valid low = bubble: RAM disabled, no counter change.
- RD:
  - An issue slot exists when beats remain unissued and (!rd_valid | rd_ready).
  - In an issue slot: ram_ena = 1, ram_we = 0, ram_addr = cur_addr. The edge captures ram_dout into rd_data, sets rd_valid and rd_last (= rd_iss == 0), and increments cur_addr.
  - Latency: address cycle to rd_valid = 1 clock. Sustained 1 beat/clock while rd_ready stays high.
  - rd_valid high & rd_ready low: rd_data and rd_valid hold, ram_ena = 0 (no issue).
  - rd_valid & rd_ready with no new issue: rd_valid clears.
  - Handshake on the beat with rd_last = 1: go to FIN.
- FIN: done = 1 for exactly one cycle, busy = 1, cmd_ready = 0; next state IDLE.
- ram_din = 0 and ram_we = 0 outside WR.
- Address arithmetic is modulo 2**ADDR_: 2**ADDR_-1 wraps to 0; no error.
- Burst of 2**LEN_ beats is allowed when cmd_len is all ones.
- A burst longer than 2**ADDR_ wraps and overwrites/rereads; no error flag.
- A new command is accepted no earlier than the cycle after FIN, so there is a minimum 1 idle cycle between bursts.
- The master never samples ram_dout while ram_ena = 0.

Test Plan:
- Write then read back: write burst at addr 0x10, len 3, data A0,A1,A2,A3, wr_valid held high -> ram_we high 4 consecutive cycles at 0x10..0x13, done one cycle after the last beat. Read 0x10, len 3, rd_ready = 1 -> rd_data A0..A3 on 4 consecutive cycles, first one cycle after the first ram_ena; done follows.
- Read backpressure: read 0x10, len 3, rd_ready pattern 1,0,0,1,0,1,1 -> each of A0..A3 delivered exactly once in order; ram_ena = 0 on every cycle with rd_valid=1 & rd_ready=0.
- Write bubbles: wr_valid pattern 1,0,1,0,0,1,1 for len 3 -> ram_we asserted only on valid cycles; addresses advance only on accepted beats; final RAM contents correct.
- Wrap-around: write at 0xFE, len 3, data 11,22,33,44 (ADDR_=8) -> writes to 0xFE,0xFF,0x00,0x01; readback matches.
- Reset mid-burst: assert rst_n low during beat 2 of a len-7 read -> rd_valid, ram_ena, busy drop immediately; after release, state is IDLE with cmd_ready = 1, and a new write burst completes normally.
- Command while busy: cmd_valid held high with a second command during a burst -> not accepted until after done; then accepted with cmd_ready = 1 in IDLE.

Source files
------------

// File: rtl/ram_burst_master_if.sv
// ram_burst_master_if: command, write-data, read-data and RAM-port signals of the burst master
interface ram_burst_master_if #(
  parameter int DATA_ = 8,
  parameter int ADDR_ = 8,
  parameter int LEN_  = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_write;
  logic [ADDR_-1:0] cmd_addr;
  logic [LEN_-1:0]  cmd_len;
  logic             wr_valid;
  logic             wr_ready;
  logic [DATA_-1:0] wr_data;
  logic             rd_valid;
  logic             rd_ready;
  logic [DATA_-1:0] rd_data;
  logic             busy;
  logic             done;
  logic             ram_ena;
  logic             ram_we;
  logic [ADDR_-1:0] ram_addr;
  logic [DATA_-1:0] ram_din;
  logic [DATA_-1:0] ram_dout;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_ena, ram_we, ram_addr, ram_din
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, ram_dout,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, ram_ena, ram_we, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_burst_master.sv
// ram_burst_master: burst read/write initiator for a single-port combinational-read RAM
module ram_burst_master #(
  parameter int DATA_ = 8,
  parameter int ADDR_ = 8,
  parameter int LEN_  = 8
) (
  input logic                clk,
  input logic                rst_n,
  ram_burst_master_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_FIN} state_t;
  state_t           r_state, w_next;
  logic [ADDR_-1:0] r_addr;
  logic [LEN_-1:0]  r_cnt;
  logic             r_pend;
  logic             r_rd_valid;
  logic             r_rd_last;
  logic [DATA_-1:0] r_rd_data;
  logic             w_wr_acc;
  logic             w_issue;
  logic             w_rd_hs;

  // r_cnt serves as both the write beat counter and the read issue counter;
  // r_pend marks that the final read beat (count 0) has not yet been issued
  assign w_wr_acc = (r_state == S_WR) && bus.wr_valid;
  assign w_issue  = (r_state == S_RD) && r_pend && (!r_rd_valid || bus.rd_ready);
  assign w_rd_hs  = r_rd_valid && bus.rd_ready;

  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= S_IDLE;
    else r_state <= w_next;

  // next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.cmd_valid) w_next = bus.cmd_write ? S_WR : S_RD;
      S_WR:    if (w_wr_acc && r_cnt == '0) w_next = S_FIN;
      S_RD:    if (w_rd_hs && r_rd_last) w_next = S_FIN;
      default: w_next = S_IDLE;
    endcase
  end

  // address, beat counter and registered read-data stage
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_addr     <= '0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      if (r_state == S_IDLE && bus.cmd_valid) begin
        r_addr <= bus.cmd_addr;
        r_cnt  <= bus.cmd_len;
        r_pend <= !bus.cmd_write;
      end
      if (w_wr_acc || w_issue) begin
        r_addr <= r_addr + 1'b1;
        if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
      end
      if (w_issue) begin
        r_rd_data <= bus.ram_dout;
        r_rd_last <= (r_cnt == '0);
        r_pend    <= (r_cnt != '0);
      end
      if (w_issue) r_rd_valid <= 1'b1;
      else if (w_rd_hs) r_rd_valid <= 1'b0;
    end

  // channel handshakes and RAM port drive; RAM is touched only on accepted or issued beats
  always_comb begin
    bus.cmd_ready = rst_n && (r_state == S_IDLE);
    bus.wr_ready  = (r_state == S_WR);
    bus.ram_ena   = w_wr_acc || w_issue;
    bus.ram_we    = w_wr_acc;
    bus.ram_addr  = (w_wr_acc || w_issue) ? r_addr : '0;
    bus.ram_din   = (r_state == S_WR) ? bus.wr_data : '0;
    bus.rd_valid  = r_rd_valid;
    bus.rd_data   = r_rd_data;
    bus.busy      = (r_state != S_IDLE);
    bus.done      = (r_state == S_FIN);
  end
endmodule

// File: tb/tb_ram_burst_master.sv
// tb_ram_burst_master: directed bursts against a RAM model with a queue-based scoreboard
module tb_ram_burst_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_burst_master_if #(.DATA_(8), .ADDR_(8), .LEN_(8)) bus ();
  ram_burst_master #(.DATA_(8), .ADDR_(8), .LEN_(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [256];
  logic [7:0] exp_mem [256];
  always @(posedge clk) if (bus.ram_ena && bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
  assign bus.ram_dout = bus.ram_ena ? mem[bus.ram_addr] : '0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_ra [$];
  logic [7:0]  exp_rd [$];
  logic [15:0] m_w;
  logic [7:0]  m_b;
  logic        prev_done = 1'b0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops expectations whenever the DUT presents a RAM access or a read beat
  always @(negedge clk) begin
    if (rst_n) begin
      check("cmd_ready_vs_busy", bus.cmd_ready, !bus.busy);
      if (bus.wr_ready) check("we_follows_wr_valid", bus.ram_we, bus.wr_valid);
      if (bus.rd_valid && !bus.rd_ready) check("ena_under_backpressure", bus.ram_ena, 0);
      if (bus.done) check("done_single_cycle", prev_done, 0);
      if (bus.ram_ena && bus.ram_we) begin
        check("write_expected", exp_wr.size() != 0, 1);
        if (exp_wr.size() != 0) begin
          m_w = exp_wr.pop_front();
          check("write_addr_data", {bus.ram_addr, bus.ram_din}, m_w);
        end
      end
      if (bus.ram_ena && !bus.ram_we) begin
        check("read_issue_expected", exp_ra.size() != 0, 1);
        if (exp_ra.size() != 0) begin
          m_b = exp_ra.pop_front();
          check("read_issue_addr", bus.ram_addr, m_b);
        end
      end
      if (bus.rd_valid && bus.rd_ready) begin
        check("read_beat_expected", exp_rd.size() != 0, 1);
        if (exp_rd.size() != 0) begin
          m_b = exp_rd.pop_front();
          check("read_beat_data", bus.rd_data, m_b);
        end
      end
      prev_done = bus.done;
    end else prev_done = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(logic wr, logic [7:0] addr, logic [7:0] len);
    int n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_len   = len;
    @(negedge clk);
    while (!bus.cmd_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("cmd_accept_in_time", n < 50, 1);
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wr_burst(logic [7:0] addr, int n, logic [31:0] dw, logic [15:0] pat, int plen, int exp_cyc, logic hold);
    int beat = 0;
    int cyc = 0;
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({addr + 8'(i), dw[8*i +: 8]});
      exp_mem[addr + 8'(i)] = dw[8*i +: 8];
    end
    send_cmd(1'b1, addr, 8'(n - 1));
    if (hold) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_write = 1'b0;
    end
    while (beat < n && cyc < 100) begin
      bus.wr_valid = (cyc < plen) ? pat[cyc] : 1'b1;
      bus.wr_data  = dw[8*beat +: 8];
      @(negedge clk);
      if (bus.wr_valid && bus.wr_ready) beat++;
      cyc++;
      tick();
    end
    bus.wr_valid = 1'b0;
    check("write_beats", beat, n);
    check("write_cycles", cyc, exp_cyc);
    @(negedge clk);
    check("write_done", bus.done, 1);
    check("write_queue_drained", exp_wr.size(), 0);
    tick();
  endtask

  task automatic rd_burst(logic [7:0] addr, int n, logic [15:0] pat, int plen, int exp_cyc);
    int cyc = 0;
    bit seen = 0;
    for (int i = 0; i < n; i++) begin
      exp_ra.push_back(addr + 8'(i));
      exp_rd.push_back(exp_mem[addr + 8'(i)]);
    end
    send_cmd(1'b0, addr, 8'(n - 1));
    while (!seen && cyc < 100) begin
      bus.rd_ready = (cyc < plen) ? pat[cyc] : 1'b1;
      @(negedge clk);
      cyc++;
      if (bus.done) seen = 1;
      tick();
    end
    bus.rd_ready = 1'b0;
    check("read_done_seen", seen, 1);
    check("read_cycles", cyc, exp_cyc);
    check("read_data_drained", exp_rd.size(), 0);
    check("read_addr_drained", exp_ra.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
    #2;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_ram_ena", bus.ram_ena, 0);
    check("rst_ram_addr", bus.ram_addr, 0);
    check("rst_ram_din", bus.ram_din, 0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check("idle_cmd_ready", bus.cmd_ready, 1);

    wr_burst(8'h10, 4, 32'hA3A2A1A0, 16'h0, 0, 4, 1'b0);
    rd_burst(8'h10, 4, 16'h0, 0, 6);

    rd_burst(8'h10, 4, 16'b1101001, 7, 9);

    wr_burst(8'h20, 4, 32'hB3B2B1B0, 16'b1100101, 7, 7, 1'b0);
    rd_burst(8'h20, 4, 16'h0, 0, 6);

    wr_burst(8'hFE, 4, 32'h44332211, 16'h0, 0, 4, 1'b0);
    rd_burst(8'hFE, 4, 16'h0, 0, 6);

    wr_burst(8'h30, 2, 32'h0000C1C0, 16'h0, 0, 2, 1'b1);
    check("held_cmd_ready_after_done", bus.cmd_ready, 1);
    rd_burst(8'h30, 2, 16'h0, 0, 4);

    exp_ra.push_back(8'h10);
    exp_ra.push_back(8'h11);
    exp_rd.push_back(exp_mem[8'h10]);
    bus.rd_ready = 1'b1;
    send_cmd(1'b0, 8'h10, 8'd7);
    tick();
    tick();
    check("pre_reset_rd_valid", bus.rd_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rd_valid", bus.rd_valid, 0);
    check("mid_rst_ram_ena", bus.ram_ena, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_cmd_ready", bus.cmd_ready, 0);
    check("mid_rst_rd_data", bus.rd_data, 0);
    bus.rd_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", bus.cmd_ready, 1);
    check("post_rst_busy", bus.busy, 0);
    check("post_rst_issue_queue", exp_ra.size(), 0);
    check("post_rst_data_queue", exp_rd.size(), 0);
    tick();
    wr_burst(8'h40, 4, 32'h5D5C5B5A, 16'h0, 0, 4, 1'b0);
    rd_burst(8'h40, 4, 16'h0, 0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
